// File: rtl/led_adc_scheduler_pkg.sv
// Shared types and constants for the LED/ADC measurement scheduler.
// Holds the FSM state encoding, front-end field widths and result channel indices.
package led_adc_scheduler_pkg;

    localparam int ADC_W = 8;
    localparam int DC_W  = 7;
    localparam int PGA_W = 4;
    localparam int DRV_W = 4;

    localparam int CH_RED  = 0;
    localparam int CH_IR   = 1;
    localparam int CH_DARK = 2;

    typedef enum logic [2:0] {
        IDLE,
        RED_SETTLE,
        RED_ACQ,
        IR_SETTLE,
        IR_ACQ,
        DARK_SETTLE,
        DARK_ACQ,
        PUBLISH
    } state_t;

    typedef struct packed {
        logic [DC_W-1:0]  red_dc;
        logic [PGA_W-1:0] red_pga;
        logic [DC_W-1:0]  ir_dc;
        logic [PGA_W-1:0] ir_pga;
        logic [DRV_W-1:0] led_drive;
    } cfg_t;

endpackage

// File: rtl/led_adc_scheduler_sample_averager.sv
// Accumulates 2^AVG_LOG2 valid ADC samples for one phase and flags rail hits.
// Shared by all three phases; it is held clear whenever no acquisition is running.
module sample_averager
    import led_adc_scheduler_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acq,
    input  logic [ADC_W-1:0] sample,
    input  logic             sample_valid,
    output logic             done,
    output logic [ADC_W-1:0] result,
    output logic             clip
);

    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt;
    logic             clip_seen;
    logic             take;
    logic             extreme;

    // Result and clip include the sample being taken, so the owner can latch them on done.
    always_comb begin
        take    = acq && sample_valid;
        extreme = (sample == '0) || (sample == '1);
        acc_sum = acc + ACC_W'(sample);
        done    = take && (cnt == LAST_IDX);
        result  = ADC_W'(acc_sum >> AVG_LOG2);
        clip    = clip_seen || (take && extreme);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            clip_seen <= 1'b0;
        end else if (!acq) begin
            acc       <= '0;
            cnt       <= '0;
            clip_seen <= 1'b0;
        end else if (take) begin
            acc       <= acc_sum;
            cnt       <= cnt + CNT_W'(1);
            clip_seen <= clip_seen || extreme;
        end
    end

endmodule

// File: rtl/led_adc_scheduler.sv
// Sequences red, IR and dark measurement phases of an optical front end and
// publishes the averaged ADC result of each phase once per frame.
module led_adc_scheduler
    import led_adc_scheduler_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic             cfg_load,
    input  logic [DC_W-1:0]  cfg_red_dc,
    input  logic [PGA_W-1:0] cfg_red_pga,
    input  logic [DC_W-1:0]  cfg_ir_dc,
    input  logic [PGA_W-1:0] cfg_ir_pga,
    input  logic [DRV_W-1:0] cfg_led_drive,
    input  logic [ADC_W-1:0] ADC,
    input  logic             adc_valid,
    output logic             LED_RED,
    output logic             LED_IR,
    output logic [DRV_W-1:0] LED_DRIVE,
    output logic [DC_W-1:0]  DC_Comp,
    output logic [PGA_W-1:0] PGA_Gain,
    output logic [ADC_W-1:0] RED_ADC_Value,
    output logic [ADC_W-1:0] IR_ADC_Value,
    output logic [ADC_W-1:0] DARK_ADC_Value,
    output logic             frame_valid,
    output logic [2:0]       clip_flags,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

    state_t           state;
    state_t           state_next;
    cfg_t             cfg_in;
    cfg_t             shadow;
    cfg_t             frame;
    logic [7:0]       settle_cnt;
    logic             in_settle;
    logic             in_acq;
    logic             settle_done;
    logic             frame_start;
    logic             avg_done;
    logic             avg_clip;
    logic [ADC_W-1:0] avg_result;
    logic [ADC_W-1:0] red_res;
    logic [ADC_W-1:0] ir_res;
    logic             clip_red;
    logic             clip_ir;

    assign cfg_in = '{red_dc: cfg_red_dc, red_pga: cfg_red_pga, ir_dc: cfg_ir_dc,
                      ir_pga: cfg_ir_pga, led_drive: cfg_led_drive};

    assign in_settle   = state inside {RED_SETTLE, IR_SETTLE, DARK_SETTLE};
    assign in_acq      = state inside {RED_ACQ, IR_ACQ, DARK_ACQ};
    assign settle_done = in_settle && (settle_cnt == SETTLE_LAST);
    assign frame_start = (state_next == RED_SETTLE) && (state != RED_SETTLE);

    sample_averager #(
        .AVG_LOG2(AVG_LOG2)
    ) u_averager (
        .clk         (CLK),
        .rst         (RST),
        .acq         (in_acq),
        .sample      (ADC),
        .sample_valid(adc_valid),
        .done        (avg_done),
        .result      (avg_result),
        .clip        (avg_clip)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (enable)      state_next = RED_SETTLE;
            RED_SETTLE:  if (settle_done) state_next = RED_ACQ;
            RED_ACQ:     if (avg_done)    state_next = IR_SETTLE;
            IR_SETTLE:   if (settle_done) state_next = IR_ACQ;
            IR_ACQ:      if (avg_done)    state_next = DARK_SETTLE;
            DARK_SETTLE: if (settle_done) state_next = DARK_ACQ;
            DARK_ACQ:    if (avg_done)    state_next = PUBLISH;
            PUBLISH:     state_next = enable ? RED_SETTLE : IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_comb begin
        LED_RED     = 1'b0;
        LED_IR      = 1'b0;
        DC_Comp     = frame.ir_dc;
        PGA_Gain    = frame.ir_pga;
        busy        = (state != IDLE);
        frame_valid = (state == PUBLISH);
        LED_DRIVE   = busy ? frame.led_drive : '0;
        case (state)
            IDLE: begin
                DC_Comp  = '0;
                PGA_Gain = '0;
            end
            RED_SETTLE, RED_ACQ: begin
                LED_RED  = 1'b1;
                DC_Comp  = frame.red_dc;
                PGA_Gain = frame.red_pga;
            end
            IR_SETTLE, IR_ACQ: LED_IR = 1'b1;
            default: ;
        endcase
    end

    // Settle counter restarts at every phase change so each SETTLE state gets a full window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            settle_cnt <= '0;
        end else if (in_settle && !settle_done) begin
            settle_cnt <= settle_cnt + 8'd1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // A strobe landing on the frame-start edge goes straight into the frame copy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow <= '0;
            frame  <= '0;
        end else begin
            if (cfg_load) begin
                shadow <= cfg_in;
            end
            if (frame_start) begin
                frame <= cfg_load ? cfg_in : shadow;
            end
        end
    end

    // Dark result is taken directly from the averager on the edge that enters PUBLISH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            red_res        <= '0;
            ir_res         <= '0;
            clip_red       <= 1'b0;
            clip_ir        <= 1'b0;
            RED_ADC_Value  <= '0;
            IR_ADC_Value   <= '0;
            DARK_ADC_Value <= '0;
            clip_flags     <= '0;
            frame_cnt      <= '0;
        end else if (avg_done) begin
            case (state)
                RED_ACQ: begin
                    red_res  <= avg_result;
                    clip_red <= avg_clip;
                end
                IR_ACQ: begin
                    ir_res  <= avg_result;
                    clip_ir <= avg_clip;
                end
                DARK_ACQ: begin
                    RED_ADC_Value        <= red_res;
                    IR_ADC_Value         <= ir_res;
                    DARK_ADC_Value       <= avg_result;
                    clip_flags[CH_RED]   <= clip_red;
                    clip_flags[CH_IR]    <= clip_ir;
                    clip_flags[CH_DARK]  <= avg_clip;
                    frame_cnt            <= frame_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_adc_scheduler.sv
// Scoreboard bench: stimulus pushes expected frame results, a monitor pops and
// compares them on every frame_valid pulse.
module tb_led_adc_scheduler;

    localparam int SETTLE = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       enable;
    logic       cfg_load;
    logic [6:0] cfg_red_dc;
    logic [3:0] cfg_red_pga;
    logic [6:0] cfg_ir_dc;
    logic [3:0] cfg_ir_pga;
    logic [3:0] cfg_led_drive;
    logic [7:0] ADC;
    logic       adc_valid;
    logic       LED_RED;
    logic       LED_IR;
    logic [3:0] LED_DRIVE;
    logic [6:0] DC_Comp;
    logic [3:0] PGA_Gain;
    logic [7:0] RED_ADC_Value;
    logic [7:0] IR_ADC_Value;
    logic [7:0] DARK_ADC_Value;
    logic       frame_valid;
    logic [2:0] clip_flags;
    logic       busy;
    logic [7:0] frame_cnt;

    led_adc_scheduler #(.SETTLE_CYC(SETTLE), .AVG_LOG2(3)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .cfg_load(cfg_load),
        .cfg_red_dc(cfg_red_dc), .cfg_red_pga(cfg_red_pga), .cfg_ir_dc(cfg_ir_dc),
        .cfg_ir_pga(cfg_ir_pga), .cfg_led_drive(cfg_led_drive), .ADC(ADC),
        .adc_valid(adc_valid), .LED_RED(LED_RED), .LED_IR(LED_IR), .LED_DRIVE(LED_DRIVE),
        .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain), .RED_ADC_Value(RED_ADC_Value),
        .IR_ADC_Value(IR_ADC_Value), .DARK_ADC_Value(DARK_ADC_Value),
        .frame_valid(frame_valid), .clip_flags(clip_flags), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] red, ir, dark;
        logic [2:0] clip;
        logic [7:0] cnt;
        logic [6:0] red_dc, ir_dc;
        logic [3:0] red_pga, ir_pga, drive;
        int         len;
    } exp_t;

    exp_t sb_q[$];

    int         checks = 0;
    int         errors = 0;
    int         frames_seen = 0;
    logic [7:0] exp_cnt = 8'd0;
    int         exp_len = 12;
    logic [6:0] sh_red_dc = '0, sh_ir_dc = '0;
    logic [3:0] sh_red_pga = '0, sh_ir_pga = '0, sh_drive = '0;
    logic [7:0] red_val = 8'd100, ir_val = 8'd200, dark_val = 8'd20;
    bit         ramp = 1'b0;
    bit         toggle = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int phaseOf();
        if (LED_RED) return 0;
        if (LED_IR) return 1;
        if (busy && !frame_valid) return 2;
        return 3;
    endfunction

    // Sample source: value depends on the lit LED; cycle index k counts from the first ACQ cycle.
    int drv_phase = 3;
    int drv_cnt = 0;
    always @(negedge CLK) begin
        int p;
        int k;
        p = phaseOf();
        if (p == drv_phase) drv_cnt++;
        else drv_cnt = 0;
        drv_phase = p;
        k = drv_cnt - SETTLE;
        adc_valid = toggle ? k[0] : 1'b1;
        case (p)
            0:       ADC = (ramp && k >= 0) ? 8'(k) : red_val;
            1:       ADC = ir_val;
            2:       ADC = dark_val;
            default: ADC = 8'hAA;
        endcase
    end

    // Monitor: tracks per-phase lengths and front-end settings, checks each published frame.
    int         mon_phase = 3, mon_len = 0, len_r = 0, len_i = 0, len_d = 0;
    logic [6:0] s_red_dc, s_ir_dc, s_dark_dc;
    logic [3:0] s_red_pga, s_ir_pga, s_dark_pga, s_drive;
    bit         unstable = 1'b0;
    always @(negedge CLK) begin
        int p;
        exp_t e;
        if (RST) begin
            mon_phase = 3;
            mon_len = 0;
            unstable = 1'b0;
        end else begin
            p = phaseOf();
            if (p != mon_phase) begin
                case (mon_phase)
                    0: len_r = mon_len;
                    1: len_i = mon_len;
                    2: len_d = mon_len;
                    default: ;
                endcase
                mon_len = 0;
                case (p)
                    0: begin s_red_dc = DC_Comp; s_red_pga = PGA_Gain; s_drive = LED_DRIVE; unstable = 1'b0; end
                    1: begin s_ir_dc = DC_Comp; s_ir_pga = PGA_Gain; end
                    2: begin s_dark_dc = DC_Comp; s_dark_pga = PGA_Gain; end
                    default: ;
                endcase
            end
            mon_len++;
            if (p == 0 && (DC_Comp !== s_red_dc || PGA_Gain !== s_red_pga || LED_IR)) unstable = 1'b1;
            if (p == 1 && (DC_Comp !== s_ir_dc || PGA_Gain !== s_ir_pga)) unstable = 1'b1;
            if (p == 2 && (DC_Comp !== s_dark_dc || PGA_Gain !== s_dark_pga)) unstable = 1'b1;
            if (busy && LED_DRIVE !== s_drive) unstable = 1'b1;
            mon_phase = p;
        end
        if (frame_valid === 1'b1) begin
            frames_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame: got frame_valid pulse, required none");
            end else begin
                e = sb_q.pop_front();
                checkOutput("red_value", 32'(RED_ADC_Value), 32'(e.red));
                checkOutput("ir_value", 32'(IR_ADC_Value), 32'(e.ir));
                checkOutput("dark_value", 32'(DARK_ADC_Value), 32'(e.dark));
                checkOutput("clip_flags", 32'(clip_flags), 32'(e.clip));
                checkOutput("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                checkOutput("red_dc", 32'(s_red_dc), 32'(e.red_dc));
                checkOutput("red_pga", 32'(s_red_pga), 32'(e.red_pga));
                checkOutput("ir_dc", 32'(s_ir_dc), 32'(e.ir_dc));
                checkOutput("ir_pga", 32'(s_ir_pga), 32'(e.ir_pga));
                checkOutput("dark_dc", 32'(s_dark_dc), 32'(e.ir_dc));
                checkOutput("dark_pga", 32'(s_dark_pga), 32'(e.ir_pga));
                checkOutput("led_drive", 32'(s_drive), 32'(e.drive));
                checkOutput("red_len", 32'(len_r), 32'(e.len));
                checkOutput("ir_len", 32'(len_i), 32'(e.len));
                checkOutput("dark_len", 32'(len_d), 32'(e.len));
                checkOutput("phase_stable", 32'(unstable), 32'd0);
            end
        end
    end

    task automatic pushExp(input logic [7:0] r, input logic [7:0] i, input logic [7:0] d, input logic [2:0] c);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.red = r; e.ir = i; e.dark = d; e.clip = c; e.cnt = exp_cnt;
        e.red_dc = sh_red_dc; e.red_pga = sh_red_pga;
        e.ir_dc = sh_ir_dc; e.ir_pga = sh_ir_pga; e.drive = sh_drive;
        e.len = exp_len;
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [6:0] rdc, input logic [3:0] rpga, input logic [6:0] idc,
                                 input logic [3:0] ipga, input logic [3:0] drv, input bit start);
        cfg_red_dc = rdc; cfg_red_pga = rpga; cfg_ir_dc = idc; cfg_ir_pga = ipga; cfg_led_drive = drv;
        cfg_load = 1'b1;
        enable = start;
        sh_red_dc = rdc; sh_red_pga = rpga; sh_ir_dc = idc; sh_ir_pga = ipga; sh_drive = drv;
        @(negedge CLK);
        cfg_load = 1'b0;
        enable = 1'b0;
    endtask

    task automatic startFrame();
        enable = 1'b1;
        @(negedge CLK);
        enable = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (!busy) return;
        end
        checkOutput({name, "_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic waitLed(input bit ir, input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if ((ir ? LED_IR : LED_RED) === 1'b1) return;
        end
        checkOutput({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic runFrame(input logic [7:0] r, input logic [7:0] i, input logic [7:0] d, input logic [2:0] c);
        pushExp(r, i, d, c);
        startFrame();
        waitIdle("frame");
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int target;
        RST = 1'b1; enable = 1'b0; cfg_load = 1'b0;
        cfg_red_dc = '0; cfg_red_pga = '0; cfg_ir_dc = '0; cfg_ir_pga = '0; cfg_led_drive = '0;
        ADC = '0; adc_valid = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_leds", 32'({LED_RED, LED_IR}), 32'd0);
        checkOutput("rst_drive", 32'(LED_DRIVE), 32'd0);
        checkOutput("rst_results", 32'({RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        applyStimulus(7'd40, 4'd7, 7'd55, 4'd9, 4'd10, 1'b0);
        runFrame(8'd100, 8'd200, 8'd20, 3'b000);

        ramp = 1'b1;
        runFrame(8'd3, 8'd200, 8'd20, 3'b001);
        ramp = 1'b0;

        red_val = 8'd128; ir_val = 8'd255; dark_val = 8'd0;
        runFrame(8'd128, 8'd255, 8'd0, 3'b110);
        red_val = 8'd100; ir_val = 8'd200; dark_val = 8'd20;

        toggle = 1'b1; exp_len = 20;
        runFrame(8'd100, 8'd200, 8'd20, 3'b000);
        toggle = 1'b0; exp_len = 12;

        pushExp(8'd100, 8'd200, 8'd20, 3'b000);
        startFrame();
        waitLed(1'b0, "wait_red");
        repeat (SETTLE + 3) @(negedge CLK);
        applyStimulus(7'd60, 4'd7, 7'd55, 4'd9, 4'd10, 1'b0);
        waitIdle("cfg_mid");
        runFrame(8'd100, 8'd200, 8'd20, 3'b000);

        applyStimulus(7'd33, 4'd5, 7'd44, 4'd6, 4'd3, 1'b1);
        pushExp(8'd100, 8'd200, 8'd20, 3'b000);
        waitIdle("bypass");

        startFrame();
        waitLed(1'b1, "wait_ir");
        repeat (SETTLE + 3) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checkOutput("abort_leds", 32'({LED_RED, LED_IR}), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_frontend", 32'({LED_DRIVE, DC_Comp, PGA_Gain}), 32'd0);
        checkOutput("abort_results", 32'({RED_ADC_Value, IR_ADC_Value, DARK_ADC_Value}), 32'd0);
        checkOutput("abort_flags_cnt", 32'({clip_flags, frame_cnt}), 32'd0);
        checkOutput("abort_frame_valid", 32'(frame_valid), 32'd0);
        sb_q.delete();
        exp_cnt = 8'd0;
        sh_red_dc = '0; sh_red_pga = '0; sh_ir_dc = '0; sh_ir_pga = '0; sh_drive = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("restart_idle", 32'(busy), 32'd0);
        runFrame(8'd100, 8'd200, 8'd20, 3'b000);

        applyStimulus(7'd40, 4'd7, 7'd55, 4'd9, 4'd10, 1'b0);
        pushExp(8'd100, 8'd200, 8'd20, 3'b000);
        enable = 1'b1;
        waitLed(1'b1, "drop_ir");
        enable = 1'b0;
        waitIdle("drop");
        checkOutput("drop_busy", 32'(busy), 32'd0);
        checkOutput("idle_drive", 32'(LED_DRIVE), 32'd0);

        target = frames_seen + 256;
        for (int n = 0; n < 256; n++) pushExp(8'd100, 8'd200, 8'd20, 3'b000);
        enable = 1'b1;
        for (int i = 0; i < 20000 && frames_seen < target - 1; i++) @(negedge CLK);
        @(posedge CLK);
        #1 enable = 1'b0;
        waitIdle("wrap");
        checkOutput("frames_total", 32'(frames_seen), 32'(target));
        checkOutput("frame_cnt_final", 32'(frame_cnt), 32'(exp_cnt));
        checkOutput("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
